// File: rtl/fp_pkg.sv
// Shared FP8 field layout, magnitude width and converter state encoding.
package fp_pkg;

    localparam int S_BIT = 7;
    localparam int E_MSB = 6;
    localparam int E_LSB = 4;
    localparam int F_MSB = 3;
    localparam int E_W   = E_MSB - E_LSB + 1;
    localparam int MAG_W = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SIGN  = 2'd2,
        OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/fp_expand.sv
// FP8 (S,E3,F4) to two's-complement integer converter: one word in flight,
// magnitude built by a serial shifter, sign applied in a single SIGN step.
module fp_expand
    import fp_pkg::*;
#(
    parameter int OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_fp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_val,
    output logic             busy
);

    state_e             state_q, state_d;
    logic               s_r_q, s_r_d;
    logic [MAG_W-1:0]   mag_q, mag_d;
    logic [E_W-1:0]     cnt_q, cnt_d;
    logic [OUT_W-1:0]   out_val_q, out_val_d;
    logic [OUT_W-1:0]   mag_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            s_r_q     <= 1'b0;
            mag_q     <= '0;
            cnt_q     <= '0;
            out_val_q <= '0;
        end else begin
            state_q   <= state_d;
            s_r_q     <= s_r_d;
            mag_q     <= mag_d;
            cnt_q     <= cnt_d;
            out_val_q <= out_val_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = (in_fp[E_MSB:E_LSB] != '0) ? SHIFT : SIGN;
            SHIFT:   if (cnt_q == E_W'(1)) state_d = SIGN;
            SIGN:    state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Upper bits of the extended magnitude are always zero, so OUT_W > 12 sign-extends for free.
    assign mag_ext = {{(OUT_W-MAG_W){1'b0}}, mag_q};

    always_comb begin
        s_r_d     = s_r_q;
        mag_d     = mag_q;
        cnt_d     = cnt_q;
        out_val_d = out_val_q;
        case (state_q)
            IDLE: if (in_valid) begin
                s_r_d = in_fp[S_BIT];
                mag_d = {{(MAG_W-F_MSB-1){1'b0}}, in_fp[F_MSB:0]};
                cnt_d = in_fp[E_MSB:E_LSB];
            end
            SHIFT: begin
                mag_d = {mag_q[MAG_W-2:0], 1'b0};
                cnt_d = cnt_q - E_W'(1);
            end
            SIGN:    out_val_d = s_r_q ? -mag_ext : mag_ext;
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = (state_q == OUT);
        out_val   = out_val_q;
    end

endmodule

// File: tb/tb_fp_expand.sv
// Directed and randomized checks of fp_expand against an arithmetic FP8 model.
module tb_fp_expand;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_fp;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_val;
    logic         busy;

    int checks = 0;
    int errors = 0;

    fp_expand #(.OUT_W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_fp(in_fp), .out_valid(out_valid), .out_ready(out_ready),
        .out_val(out_val), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: (-1)^S * F * 2^E as plain integer arithmetic.
    function automatic int ref_val(input logic [7:0] fp);
        int m;
        m = int'(fp[3:0]) * (1 << int'(fp[6:4]));
        return fp[7] ? -m : m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_val"}, 32'(out_val), 32'd0);
    endtask

    // Send one word, check latency, in-flight flags, value, stall hold and release.
    task automatic run_word(input logic [7:0] fp, input int stall);
        int edges;
        logic [W-1:0] exp_v;
        logic [W-1:0] held;
        exp_v = W'(ref_val(fp));
        chk("pre_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_fp    = fp;
        step();
        edges = 1;
        in_fp = 8'($urandom);
        while (!out_valid && edges < 40) begin
            chk("inflight_in_ready", 32'(in_ready), 32'd0);
            chk("inflight_busy", 32'(busy), 32'd1);
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            in_fp     = 8'($urandom);
            step();
            edges++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("latency", 32'(edges), 32'(int'(fp[6:4]) + 2));
        chk("out_val", 32'(out_val), 32'(exp_v));
        held = out_val;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom);
            step();
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out_val", 32'(out_val), 32'(held));
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_out_val_kept", 32'(out_val), 32'(exp_v));
    endtask

    initial begin
        logic [7:0] fp;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_fp     = 8'h00;
        out_ready = 1'b0;
        step();
        step();
        chk_idle_reset("reset");
        rst = 1'b0;

        run_word(8'h2E, 0);
        run_word(8'hAA, 0);
        run_word(8'h5D, 1);
        run_word(8'h7F, 0);
        run_word(8'hFF, 2);
        run_word(8'h80, 0);
        run_word(8'hF0, 0);
        run_word(8'h05, 0);
        run_word(8'h3C, 5);

        // Reset mid-SHIFT discards the word with no output pulse.
        in_valid = 1'b1;
        in_fp    = 8'h7F;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle_reset("rst_shift");
        for (int i = 0; i < 10; i++) begin
            step();
            chk("rst_shift_no_pulse", 32'(out_valid), 32'd0);
        end
        run_word(8'h2E, 0);

        // Reset in OUT clears the held result; reset beats a same-edge capture.
        in_valid = 1'b1;
        in_fp    = 8'h15;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        rst      = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        rst      = 1'b0;
        chk_idle_reset("rst_out");
        step();
        chk("rst_blocks_capture_busy", 32'(busy), 32'd0);

        for (int n = 0; n < 40; n++) begin
            fp = 8'($urandom);
            run_word(fp, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
